// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-space search scheduler.
package rc4_pkg;

  // Width of the searched key space (2^22 candidate keys).
  localparam int KEY_BITS        = 22;
  // Width of a secret key reported by a decryption core.
  localparam int SECRET_KEY_BITS = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FOUND,
    S_EXHAUSTED
  } sched_state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx;
  logic hit;

  // Scan from ptr with wrap-around and grant the first active request.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    grant = '0;
    hit   = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!hit && req[idx]) begin
        grant[idx] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_space_scheduler.sv
// Dispatches fixed-size key blocks to decryption cores and collects the result.
module key_space_scheduler
  import rc4_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int BLOCK_BITS = 16
) (
  input  logic                                 CLOCK_50,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [NUM_CORES-1:0]                 core_req,
  input  logic [NUM_CORES-1:0]                 core_block_done,
  input  logic [NUM_CORES-1:0]                 core_found,
  input  logic [NUM_CORES*SECRET_KEY_BITS-1:0] core_key,
  output logic [NUM_CORES-1:0]                 core_grant,
  output logic [KEY_BITS-1:0]                  grant_base,
  output logic                                 stop_cores,
  output logic                                 found,
  output logic                                 not_found,
  output logic [SECRET_KEY_BITS-1:0]           found_key,
  output logic [2:0]                           found_core,
  output logic                                 busy
);

  localparam int                PW         = $clog2(NUM_CORES);
  localparam int                BASE_W     = KEY_BITS + 1;
  localparam logic [BASE_W-1:0] BLOCK_STEP = BASE_W'(1) << BLOCK_BITS;

  sched_state_t                 state, state_nxt;
  logic [NUM_CORES-1:0]         busy_vec, arb_req, arb_grant;
  logic [BASE_W-1:0]            next_base;
  logic [PW-1:0]                rr_ptr, ptr_nxt;
  logic                         do_start, do_grant, do_found, do_track, do_exhaust;
  logic [2:0]                   win_idx;
  logic [SECRET_KEY_BITS-1:0]   key_sel;

  // A busy core's held request is not a request.
  assign arb_req = core_req & ~busy_vec;
  assign busy    = (state == S_RUN) || (state == S_DRAIN);
  assign win_idx = lowest_set(8'(core_found));

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  // Pointer moves to one position past the core being granted.
  always_comb begin
    ptr_nxt = rr_ptr;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (arb_grant[i]) ptr_nxt = (i == NUM_CORES - 1) ? '0 : PW'(i + 1);
    end
  end

  // Select the matched key reported by the winning core.
  always_comb begin
    key_sel = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (win_idx == 3'(i)) key_sel = core_key[i*SECRET_KEY_BITS +: SECRET_KEY_BITS];
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath control; a found match beats block_done and grants.
  always_comb begin
    state_nxt  = state;
    do_start   = 1'b0;
    do_grant   = 1'b0;
    do_found   = 1'b0;
    do_track   = 1'b0;
    do_exhaust = 1'b0;
    case (state)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (start) begin
          do_start  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (|core_found) begin
          do_found  = 1'b1;
          state_nxt = S_FOUND;
        end else begin
          do_track = 1'b1;
          if (next_base[KEY_BITS]) state_nxt = S_DRAIN;
          else if (|arb_req)       do_grant  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (|core_found) begin
          do_found  = 1'b1;
          state_nxt = S_FOUND;
        end else begin
          do_track = 1'b1;
          if (busy_vec == '0) begin
            do_exhaust = 1'b1;
            state_nxt  = S_EXHAUSTED;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: grant pulse, block counter, busy tracking and result latch.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      core_grant <= '0;
      grant_base <= '0;
      stop_cores <= 1'b0;
      found      <= 1'b0;
      not_found  <= 1'b0;
      found_key  <= '0;
      found_core <= '0;
      busy_vec   <= '0;
      next_base  <= '0;
      rr_ptr     <= '0;
    end else begin
      core_grant <= '0;
      grant_base <= '0;
      if (do_start) begin
        next_base  <= '0;
        busy_vec   <= '0;
        rr_ptr     <= '0;
        stop_cores <= 1'b0;
        found      <= 1'b0;
        not_found  <= 1'b0;
        found_key  <= '0;
        found_core <= '0;
      end
      if (do_track) busy_vec <= (busy_vec & ~core_block_done) | (do_grant ? arb_grant : '0);
      if (do_grant) begin
        core_grant <= arb_grant;
        grant_base <= next_base[KEY_BITS-1:0];
        next_base  <= next_base + BLOCK_STEP;
        rr_ptr     <= ptr_nxt;
      end
      if (do_found) begin
        found      <= 1'b1;
        stop_cores <= 1'b1;
        found_key  <= key_sel;
        found_core <= win_idx;
      end
      if (do_exhaust) not_found <= 1'b1;
    end
  end

endmodule
